// File: rtl/fan_mode_ctrl.sv
// Fan controller scheduler: fixed-priority press arbitration, OFF/RUN/TIMED FSM, countdown timer, PWM drive.
// Optional macro FAN_SOFTSTART_EN ramps the effective PWM duty after each power-on.
module fan_mode_ctrl #(
  parameter int PWM_W    = 4,
  parameter int DUTY1    = 5,
  parameter int DUTY2    = 10,
  parameter int DUTY3    = 15,
  parameter int TMR_W    = 8,
  parameter int TMR_STEP = 30,
  parameter int TMR_MAX  = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1s,
  input  logic             press_pwr,
  input  logic             press_tmr,
  input  logic             press_up,
  input  logic             press_dn,
  output logic [1:0]       state,
  output logic             fan_on,
  output logic [1:0]       speed,
  output logic [TMR_W-1:0] timer_left,
  output logic             pwm_out,
  output logic             drop_evt
);
  typedef enum logic [1:0] {S_OFF = 2'd0, S_RUN = 2'd1, S_TIMED = 2'd2, S_BAD = 2'd3} st_e;

  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] T_STEP = TMR_W'(TMR_STEP);
  localparam logic [TMR_W-1:0] T_MAX  = TMR_W'(TMR_MAX);
  localparam logic [TMR_W:0]   STEP_X = (TMR_W+1)'(TMR_STEP);
  localparam logic [TMR_W:0]   MAX_X  = (TMR_W+1)'(TMR_MAX);
  localparam logic [PWM_W:0]   D1 = (PWM_W+1)'(DUTY1);
  localparam logic [PWM_W:0]   D2 = (PWM_W+1)'(DUTY2);
  localparam logic [PWM_W:0]   D3 = (PWM_W+1)'(DUTY3);

  st_e              st_q, st_d;
  logic [1:0]       spd_d, spd_up, spd_dn;
  logic [TMR_W-1:0] tmr_d;
  logic [TMR_W:0]   tmr_sum;
  logic             drop_d, fan_d, multi;
  logic             a_pwr, a_tmr, a_up, a_dn;
  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W:0]   duty, cmp_duty;

  // Fixed priority pwr > tmr > up > dn; losers are simply discarded.
  assign a_pwr = press_pwr;
  assign a_tmr = press_tmr & ~press_pwr;
  assign a_up  = press_up  & ~press_pwr & ~press_tmr;
  assign a_dn  = press_dn  & ~press_pwr & ~press_tmr & ~press_up;
  assign multi = (press_pwr & (press_tmr | press_up | press_dn)) |
                 (press_tmr & (press_up | press_dn)) | (press_up & press_dn);

  assign spd_up  = (speed == 2'd3) ? 2'd3 : speed + 2'd1;
  assign spd_dn  = (speed <= 2'd1) ? 2'd1 : speed - 2'd1;
  assign tmr_sum = {1'b0, timer_left} + STEP_X;

  always_comb begin
    st_d   = st_q;
    spd_d  = speed;
    tmr_d  = timer_left;
    drop_d = multi;
    case (st_q)
      S_OFF: begin
        // In OFF only pwr matters, so only a collision with pwr counts as a drop.
        drop_d = press_pwr & (press_tmr | press_up | press_dn);
        if (a_pwr) begin
          st_d  = S_RUN;
          spd_d = 2'd1;
          tmr_d = '0;
        end
      end
      S_RUN: begin
        if (a_pwr) begin
          st_d  = S_OFF;
          spd_d = 2'd0;
          tmr_d = '0;
        end else if (a_tmr) begin
          st_d  = S_TIMED;
          tmr_d = T_STEP;
        end else if (a_up) spd_d = spd_up;
        else if (a_dn)     spd_d = spd_dn;
      end
      S_TIMED: begin
        if (a_pwr) begin
          st_d  = S_OFF;
          spd_d = 2'd0;
          tmr_d = '0;
        end else if (a_tmr) begin
          if (timer_left == T_MAX) begin
            st_d  = S_RUN;
            tmr_d = '0;
          end else begin
            tmr_d = (tmr_sum > MAX_X) ? T_MAX : tmr_sum[TMR_W-1:0];
          end
        end else begin
          // up/dn and a coincident tick are both applied; expiry overrides speed.
          if (a_up)      spd_d = spd_up;
          else if (a_dn) spd_d = spd_dn;
          if (tick_1s) begin
            if (timer_left > T_ONE) tmr_d = timer_left - T_ONE;
            else begin
              st_d  = S_OFF;
              spd_d = 2'd0;
              tmr_d = '0;
            end
          end
        end
      end
      default: begin
        st_d   = S_OFF;
        spd_d  = 2'd0;
        tmr_d  = '0;
        drop_d = 1'b0;
      end
    endcase
  end

  assign fan_d = (st_d == S_RUN) || (st_d == S_TIMED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= S_OFF;
      fan_on     <= 1'b0;
      speed      <= 2'd0;
      timer_left <= '0;
      drop_evt   <= 1'b0;
    end else begin
      st_q       <= st_d;
      fan_on     <= fan_d;
      speed      <= spd_d;
      timer_left <= tmr_d;
      drop_evt   <= drop_d;
    end
  end

  assign state = st_q;

  always_comb begin
    case (speed)
      2'd1:    duty = D1;
      2'd2:    duty = D2;
      2'd3:    duty = D3;
      default: duty = '0;
    endcase
  end

`ifdef FAN_SOFTSTART_EN
  logic [PWM_W:0] eff_q;

  // Ramp one step per PWM period after power-on; follow speed decreases at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) eff_q <= '0;
    else if (st_q == S_OFF) eff_q <= (st_d == S_RUN) ? (PWM_W+1)'(1) : '0;
    else if (eff_q > duty) eff_q <= duty;
    else if ((&cnt_q) && (eff_q < duty)) eff_q <= eff_q + (PWM_W+1)'(1);
  end

  assign cmp_duty = eff_q;
`else
  assign cmp_duty = duty;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + PWM_W'(1);
      pwm_out <= fan_on && ({1'b0, cnt_q} < cmp_duty);
    end
  end
endmodule

// File: tb/tb_fan_mode_ctrl.sv
// Scoreboard bench for fan_mode_ctrl: directed test-plan sequences plus random presses/ticks/resets.
module tb_fan_mode_ctrl;
  logic       clk = 1'b0;
  logic       reset, tick_1s, press_pwr, press_tmr, press_up, press_dn;
  logic [1:0] state, speed;
  logic       fan_on, pwm_out, drop_evt;
  logic [7:0] timer_left;

`ifdef FAN_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  fan_mode_ctrl dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s),
    .press_pwr(press_pwr), .press_tmr(press_tmr), .press_up(press_up), .press_dn(press_dn),
    .state(state), .fan_on(fan_on), .speed(speed), .timer_left(timer_left),
    .pwm_out(pwm_out), .drop_evt(drop_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int fan; int spd; int tmr; int pwm; int drop;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: what the outputs should be, plus cycles since reset and ramp duty.
  int m_st = 0, m_spd = 0, m_tmr = 0, m_fan = 0, m_pwm = 0, m_drop = 0;
  int m_cyc = 0, m_eff = 0;

  function automatic int duty_of(int s);
    return (s == 1) ? 5 : (s == 2) ? 10 : (s == 3) ? 15 : 0;
  endfunction

  task automatic apply(input bit r, input bit pw, input bit tm, input bit u, input bit d, input bit tk);
    int n_st, n_spd, n_tmr, n_eff, presses, thr;
    exp_t e;
    @(negedge clk);
    reset = r; press_pwr = pw; press_tmr = tm; press_up = u; press_dn = d; tick_1s = tk;
    if (!r) begin
      m_st = 0; m_spd = 0; m_tmr = 0; m_fan = 0; m_pwm = 0; m_drop = 0; m_cyc = 0; m_eff = 0;
      #1;
      n_vec++;
      if (state !== 2'd0 || fan_on !== 1'b0 || speed !== 2'd0 || timer_left !== 8'd0 ||
          pwm_out !== 1'b0 || drop_evt !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset: got st=%0d fan=%0d spd=%0d tmr=%0d pwm=%0d drop=%0d, want all 0",
                 state, fan_on, speed, timer_left, pwm_out, drop_evt);
      end
    end else begin
      presses = int'(pw) + int'(tm) + int'(u) + int'(d);
      n_st = m_st; n_spd = m_spd; n_tmr = m_tmr;
      thr = SOFT ? m_eff : duty_of(m_spd);
      // Counter position equals cycles since reset mod 16.
      m_pwm = (m_fan != 0 && (m_cyc % 16) < thr) ? 1 : 0;
      if (m_st == 0) begin
        m_drop = (pw && presses > 1) ? 1 : 0;
        if (pw) begin n_st = 1; n_spd = 1; end
      end else begin
        m_drop = (presses > 1) ? 1 : 0;
        if (pw) begin n_st = 0; n_spd = 0; n_tmr = 0; end
        else if (tm) begin
          if (m_st == 1) begin n_st = 2; n_tmr = 30; end
          else if (m_tmr == 120) begin n_st = 1; n_tmr = 0; end
          else n_tmr = (m_tmr + 30 > 120) ? 120 : m_tmr + 30;
        end else begin
          if (u) n_spd = (m_spd + 1 > 3) ? 3 : m_spd + 1;
          else if (d) n_spd = (m_spd - 1 < 1) ? 1 : m_spd - 1;
          if (m_st == 2 && tk) begin
            if (m_tmr > 1) n_tmr = m_tmr - 1;
            else begin n_st = 0; n_spd = 0; n_tmr = 0; end
          end
        end
      end
      n_eff = m_eff;
      if (m_st == 0) n_eff = (n_st == 1) ? 1 : 0;
      else if (m_eff > duty_of(m_spd)) n_eff = duty_of(m_spd);
      else if ((m_cyc % 16) == 15 && m_eff < duty_of(m_spd)) n_eff = m_eff + 1;
      m_eff = n_eff;
      m_st = n_st; m_spd = n_spd; m_tmr = n_tmr; m_fan = (n_st != 0) ? 1 : 0;
      m_cyc++;
    end
    e.st = m_st; e.fan = m_fan; e.spd = m_spd; e.tmr = m_tmr; e.pwm = m_pwm; e.drop = m_drop;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every clock the DUT presents a fresh registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (int'(state) != e.st || int'(fan_on) != e.fan || int'(speed) != e.spd ||
            int'(timer_left) != e.tmr || int'(pwm_out) != e.pwm || int'(drop_evt) != e.drop) begin
          n_bad++;
          $display("FAIL outputs @%0t: got st=%0d fan=%0d spd=%0d tmr=%0d pwm=%0d drop=%0d, want st=%0d fan=%0d spd=%0d tmr=%0d pwm=%0d drop=%0d",
                   $time, state, fan_on, speed, timer_left, pwm_out, drop_evt,
                   e.st, e.fan, e.spd, e.tmr, e.pwm, e.drop);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; tick_1s = 0; press_pwr = 0; press_tmr = 0; press_up = 0; press_dn = 0;
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0);
    idle(2);
    // Power on, watch several PWM periods at speed 1.
    apply(1, 1, 0, 0, 0, 0);
    idle(40);
    for (int i = 0; i < 3; i++) begin apply(1, 0, 0, 1, 0, 0); idle(3); end
    idle(20);
    for (int i = 0; i < 3; i++) begin apply(1, 0, 0, 0, 1, 0); idle(3); end
    // Collision pwr+up in RUN: OFF plus one-cycle drop.
    apply(1, 1, 0, 1, 0, 0);
    idle(3);
    // Collisions in OFF without pwr: no drop expected.
    apply(1, 0, 1, 1, 1, 1);
    idle(2);
    apply(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin apply(1, 0, 1, 0, 0, 0); idle(2); end
    // Countdown to expiry.
    apply(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 28; i++) apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1);
    idle(3);
    // Tick coincident with tmr at 30 -> 60.
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) apply(1, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 1, 0, 1);
    apply(1, 0, 0, 1, 0, 0);
    idle(7);
    // Reset mid-countdown and mid-period.
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    idle(2);
    // Power on at speed 3 for the soft-start ramp (or full duty without it).
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    idle(16 * 16);
    apply(1, 0, 0, 0, 1, 0);
    idle(40);
    for (int i = 0; i < 4000; i++) begin
      apply(($urandom_range(0, 599) != 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0));
    end
    idle(2);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
